mem_responder: RTL and testbench

Native-memory-interface responder (slave) for the vector coprocessor top level. It accepts the `mem_valid`/`mem_ready` requests that the core issues on `memory_wdata`/`memory_wstrb`, and serves them from an internal word array with programmable wait states. It replaces the behavioural memory in benches and serves as the on-chip scratch RAM in synthesis.

---
 rtl/mem_if_pkg.sv | 41 ++++
 rtl/wait_lfsr.sv | 39 +++
 rtl/mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_if_pkg
// Purpose  : Shared definitions for the native-memory-interface responder:
//            FSM state encoding, out-of-range data pattern, LFSR seed,
//            read strobe value and a byte-lane merge helper.
// Revision : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

    // Responder FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    // Returned on any access outside the mapped window
    localparam logic [31:0] MEM_OOB_DATA = 32'hDEAD_BEEF;

    // Wait-state LFSR reset seed
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // All strobes clear marks a read
    localparam logic [3:0] WSTRB_READ = 4'b0000;

    // Replace only the byte lanes whose strobe is set
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wait_lfsr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wait_lfsr
// Purpose  : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, with advance enable
//            and synchronous seed load. Reset returns it to LFSR_SEED.
// Revision : 1.0 - initial release
// ============================================================================
module wait_lfsr
    import mem_if_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    output logic [7:0] o_q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

    // Seed load wins over advancing; one shift per enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= LFSR_SEED;
        end else if (i_load) begin
            r_q <= i_seed;
        end else if (i_en) begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Native memory interface slave backed by a MEM_WORDS x 32 word
//            array with byte enables and programmable wait states.
//            Optional macro MEM_RESPONDER_RANDOM_WAIT_EN adds lfsr[2:0]
//            pseudo-random extra wait states per request.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err_oob,
    output logic [15:0] xfer_count
);

    localparam int          c_IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [4:0]  c_WAIT_BASE = 5'(WAIT_CYCLES);
    localparam logic [32:0] c_END_ADDR  = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               w_ready;
    logic [4:0]         r_wcnt;
    logic [4:0]         w_wait_val;
    logic               w_accept;
    logic               w_commit;

    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_instr;

    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_wstrb;
    logic               w_is_write;
    logic               w_oob;
    logic [31:0]        w_offset;
    logic [c_IDX_W-1:0] w_idx;

    logic [31:0]        r_mem [MEM_WORDS];
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [15:0]        r_xfer;
    logic [15:0]        r_unused_fetch_count;
    logic               w_unused;

`ifdef MEM_RESPONDER_RANDOM_WAIT_EN
    logic [7:0] w_lfsr;

    wait_lfsr u_wait_lfsr (
        .clk    (clk),
        .rst    (reset),
        .i_en   (w_accept),
        .i_load (1'b0),
        .i_seed (LFSR_SEED),
        .o_q    (w_lfsr)
    );

    assign w_wait_val = c_WAIT_BASE + {2'b00, w_lfsr[2:0]};
    assign w_unused   = ^{w_offset[1:0], w_offset[31:c_IDX_W+2], w_lfsr[7:3]};
`else
    assign w_wait_val = c_WAIT_BASE;
    assign w_unused   = ^{w_offset[1:0], w_offset[31:c_IDX_W+2]};
`endif

    assign w_accept = (r_state == c_ST_IDLE) && mem_valid;

    // A zero-wait request commits straight out of IDLE, before the latch holds it
    assign w_addr     = (r_state == c_ST_IDLE) ? mem_addr  : r_addr;
    assign w_wdata    = (r_state == c_ST_IDLE) ? mem_wdata : r_wdata;
    assign w_wstrb    = (r_state == c_ST_IDLE) ? mem_wstrb : r_wstrb;
    assign w_is_write = (w_wstrb != WSTRB_READ);
    assign w_oob      = (w_addr < BASE_ADDR) || ({1'b0, w_addr} >= c_END_ADDR);
    assign w_offset   = w_addr - BASE_ADDR;
    assign w_idx      = w_offset[c_IDX_W+1:2];

    // Access takes effect on the edge that enters RESP
    assign w_commit = (w_next_state == c_ST_RESP);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and response strobe
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (mem_valid) begin
                    w_next_state = (w_wait_val == 5'd0) ? c_ST_RESP : c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (!mem_valid) begin
                    w_next_state = c_ST_IDLE;
                end else if (r_wcnt <= 5'd1) begin
                    w_next_state = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                w_ready      = 1'b1;
                w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Request latch and wait-state down-counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wstrb <= WSTRB_READ;
            r_instr <= 1'b0;
            r_wcnt  <= 5'd0;
        end else if (w_accept) begin
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_instr <= mem_instr;
            r_wcnt  <= w_wait_val;
        end else if (r_state == c_ST_WAIT) begin
            r_wcnt  <= r_wcnt - 5'd1;
        end
    end

    // Word array with byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (w_commit && !w_oob && w_is_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response data, sticky range error and transfer counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata              <= 32'h0;
            r_err                <= 1'b0;
            r_xfer               <= 16'h0;
            r_unused_fetch_count <= 16'h0;
        end else begin
            if (w_commit) begin
                r_rdata <= w_oob ? MEM_OOB_DATA
                                 : merge_lanes(r_mem[w_idx], w_wdata, w_wstrb);
                if (w_oob) begin
                    r_err <= 1'b1;
                end
            end
            if (w_ready) begin
                r_xfer <= r_xfer + 16'd1;
                if (r_instr) begin
                    r_unused_fetch_count <= r_unused_fetch_count + 16'd1;
                end
            end
        end
    end

    assign mem_ready  = w_ready;
    assign mem_rdata  = r_rdata;
    assign err_oob    = r_err;
    assign xfer_count = r_xfer;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Randomised bench for mem_responder with a word-array reference
//            model and a scoreboard-driven response monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int          MW   = 64;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          WC   = 2;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr  = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err_oob;
    logic [15:0] xfer_count;

    mem_responder #(
        .MEM_WORDS   (MW),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .err_oob    (err_oob),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          start;
    } exp_t;

    exp_t        sb[$];
    int          lat_log[$];
    int          lat_a[$];
    logic [31:0] model_mem [MW];
    logic        model_err = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    logic [15:0] done = 16'h0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_oob(input logic [31:0] a);
        return (a < BASE) || ({1'b0, a} >= ({1'b0, BASE} + 33'(4 * MW)));
    endfunction

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: pops the scoreboard on every response strobe
    initial forever begin
        exp_t e;
        int   lat;
        @(negedge clk);
        if (reset) begin
            last_rdata = 32'h0;
            done       = 16'h0;
        end else if (mem_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", {31'b0, mem_ready}, 32'h0);
            end else begin
                e   = sb.pop_front();
                lat = cyc - e.start;
                check("rdata", mem_rdata, e.rdata);
                check("err_oob", {31'b0, err_oob}, {31'b0, e.err});
                check("xfer_count", {16'h0, xfer_count}, {16'h0, done});
`ifdef MEM_RESPONDER_RANDOM_WAIT_EN
                total++;
                if (lat < WC + 1 || lat > WC + 8) begin
                    bad++;
                    $display("FAIL latency: got %0d expected in [%0d,%0d]", lat, WC + 1, WC + 8);
                end
`else
                check("latency", lat, WC + 1);
`endif
                lat_log.push_back(lat);
                last_rdata = e.rdata;
                done       = done + 16'd1;
            end
        end else begin
            check("rdata_hold", mem_rdata, last_rdata);
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_instr = 1'($urandom_range(0, 1));
        mem_valid = 1'b1;
    endtask

    // full transfer: model update, scoreboard push, wait for ready; call at posedge+1
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int   idx;
        bit   got;
        if (is_oob(a)) begin
            e.rdata   = 32'hDEAD_BEEF;
            model_err = 1'b1;
        end else begin
            idx = int'((a - BASE) >> 2);
            for (int i = 0; i < 4; i++) begin
                if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
            end
            e.rdata = model_mem[idx];
        end
        e.err   = model_err;
        e.start = cyc;
        sb.push_back(e);
        drive(a, d, s);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (mem_ready) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no mem_ready expected one for addr %h", a);
            sb.delete();
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_valid = 1'b0;
        reset     = 1'b1;
        sb.delete();
        model_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] old_w;
        logic [15:0] cnt_before;
        int          r;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(10);
        check("rst_ready", {31'b0, mem_ready}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_err", {31'b0, err_oob}, 32'h0);
        check("rst_xfer", {16'h0, xfer_count}, 32'h0);

        // initialise the words used by random traffic
        for (int w = 0; w < 16; w++) xfer(BASE + 32'(4 * w), $urandom, 4'hF);

        // full write then read back
        xfer(BASE + 32'h10, 32'h1234_5678, 4'hF);
        xfer(BASE + 32'h10, 32'h0, 4'h0);
        check("read_back", mem_rdata, 32'h1234_5678);
        check("count_after_two", {16'h0, xfer_count}, 32'd18);

        // partial strobes
        xfer(BASE + 32'h10, 32'hAABB_CCDD, 4'b0101);
        xfer(BASE + 32'h10, 32'h0, 4'h0);
        check("lane_merge", mem_rdata, 32'h12BB_56DD);

        // out of range: one past the end, then below the base
        xfer(BASE + 32'(4 * MW), 32'h0, 4'h0);
        check("oob_rdata", mem_rdata, 32'hDEAD_BEEF);
        check("oob_err", {31'b0, err_oob}, 32'h1);
        xfer(BASE - 32'h4, 32'h5555_AAAA, 4'hF);
        xfer(BASE + 32'h4, 32'h0, 4'h0);
        check("oob_sticky", {31'b0, err_oob}, 32'h1);

        // randomised traffic
        for (int t = 0; t < 150; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
            else if (r == 1) a = BASE + 32'(4 * MW) + 32'(4 * $urandom_range(0, 3));
            else             a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            d = $urandom;
            xfer(a, d, s);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        // abort: valid drops while waiting
        old_w      = model_mem[3];
        cnt_before = done;
        drive(BASE + 32'hC, ~old_w, 4'hF);
        idle(1);
        mem_valid = 1'b0;
        idle(5);
        check("abort_count", {16'h0, xfer_count}, {16'h0, cnt_before});
        xfer(BASE + 32'hC, 32'h0, 4'h0);
        check("abort_word", mem_rdata, old_w);

        // reset in the middle of a waiting write
        drive(BASE + 32'hC, ~old_w, 4'hF);
        idle(1);
        reset     = 1'b1;
        mem_valid = 1'b0;
        #2;
        check("midrst_ready", {31'b0, mem_ready}, 32'h0);
        check("midrst_xfer", {16'h0, xfer_count}, 32'h0);
        check("midrst_rdata", mem_rdata, 32'h0);
        check("midrst_err", {31'b0, err_oob}, 32'h0);
        sb.delete();
        model_err = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        xfer(BASE + 32'hC, 32'h0, 4'h0);
        check("midrst_word", mem_rdata, old_w);

        // 200 back-to-back reads, repeated after reset
        do_reset();
        lat_log.delete();
        for (int t = 0; t < 200; t++) xfer(BASE + 32'(4 * $urandom_range(0, 15)), 32'h0, 4'h0);
        lat_a = lat_log;
        do_reset();
        lat_log.delete();
        for (int t = 0; t < 200; t++) xfer(BASE + 32'(4 * $urandom_range(0, 15)), 32'h0, 4'h0);
        check("lat_count", lat_log.size(), lat_a.size());
        for (int t = 0; t < 200 && t < lat_a.size() && t < lat_log.size(); t++) begin
            check("lat_repeat", lat_log[t], lat_a[t]);
        end

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
